// File: rtl/nn_pkg.sv
// Shared types and helpers for the fully connected layer sequencer and its weight store.
package nn_pkg;

  localparam int DW_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    EMIT,
    DONE
  } state_t;

  // Index widths must stay at least one bit even for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nn_weight_rom.sv
// Weight store: synchronous word memory with one-cycle registered read.
// Contents are preloaded through the load port before a layer is sequenced.
module nn_weight_rom
  import nn_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = DW_DEFAULT,
  parameter int AW    = clog2_min1(DEPTH)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data
);

  logic [DW-1:0] mem [DEPTH];

  // No reset on the array or read register so the store maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
    if (rd_en) begin
      data <= mem[addr];
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Streams one layer's weights neuron by neuron, drives the MAC strobes aligned
// with the returned read data and hands each finished neuron downstream.
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int SIZE  = 2,
  parameter int COUNT = 1,
  parameter int DW    = DW_DEFAULT,
  parameter int AW    = clog2_min1(SIZE * COUNT),
  parameter int IW    = clog2_min1(SIZE),
  parameter int NW    = clog2_min1(COUNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          w_rd_en,
  output logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  output logic          mac_en,
  output logic          mac_first,
  output logic [DW-1:0] mac_w,
  output logic [IW-1:0] mac_x_idx,
  output logic          res_valid,
  output logic [NW-1:0] res_idx,
  input  logic          res_ready
);

  localparam logic [IW-1:0] I_LAST = IW'(SIZE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(COUNT - 1);
  localparam logic [AW-1:0] A_LAST = AW'(SIZE * COUNT - 1);

  state_t        state_reg, state_next;
  logic [NW-1:0] n_reg, n_next;
  logic [IW-1:0] i_reg, i_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic          mac_en_reg, mac_first_reg;
  logic [IW-1:0] mac_x_idx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      i_reg     <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      i_reg     <= i_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    i_next     = i_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next = FETCH;
          n_next     = '0;
          i_next     = '0;
          addr_next  = '0;
        end
      end
      FETCH: begin
        // Wrap after the final word so the address never leaves the store.
        addr_next = (addr_reg == A_LAST) ? '0 : addr_reg + 1'b1;
        if (i_reg == I_LAST) begin
          i_next     = '0;
          state_next = DRAIN;
        end else begin
          i_next = i_reg + 1'b1;
        end
      end
      DRAIN: state_next = EMIT;
      EMIT: begin
        if (res_ready) begin
          if (n_reg == N_LAST) begin
            state_next = DONE;
          end else begin
            n_next     = n_reg + 1'b1;
            i_next     = '0;
            state_next = FETCH;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        n_next     = '0;
        i_next     = '0;
        addr_next  = '0;
      end
      default: state_next = IDLE;
    endcase
    if (abort && state_reg != IDLE) begin
      state_next = IDLE;
      n_next     = '0;
      i_next     = '0;
      addr_next  = '0;
    end
  end

  // MAC strobes lag the read by one cycle to line up with the store's data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_en_reg    <= 1'b0;
      mac_first_reg <= 1'b0;
      mac_x_idx_reg <= '0;
    end else begin
      mac_en_reg    <= w_rd_en && !abort;
      mac_first_reg <= w_rd_en && !abort && (i_reg == '0);
      mac_x_idx_reg <= abort ? '0 : i_reg;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign w_rd_en   = (state_reg == FETCH);
  assign w_addr    = addr_reg;
  assign mac_en    = mac_en_reg;
  assign mac_first = mac_first_reg;
  assign mac_x_idx = mac_x_idx_reg;
  assign mac_w     = w_data;
  assign res_valid = (state_reg == EMIT);
  assign res_idx   = n_reg;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench: two sequencer/store pairs (2x3 and 1x4); expected events are
// planned from the layer timing rules and matched by a negedge monitor.
module tb_nn_layer_sequencer;
  import nn_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] val;
    logic        first;
    int          idx;
  } ev_t;

  typedef struct {
    int cyc;
    int u;
    int kind;
    int val;
  } sc_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]       start_v  = '0;
  logic [1:0]       abort_v  = '0;
  logic [1:0]       ready_v  = '0;
  logic [1:0]       ld_en_v  = '0;
  logic [1:0][7:0]  ld_addr_v;
  logic [1:0][31:0] ld_data_v;

  logic [1:0]       busy_x, done_x, rd_x, mac_en_x, first_x, rv_x;
  logic [1:0][7:0]  addr_x, xi_x, ri_x;
  logic [1:0][31:0] mw_x;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int SZ  = (gi == 0) ? 2 : 1;
      localparam int CN  = (gi == 0) ? 3 : 4;
      localparam int AWL = clog2_min1(SZ * CN);
      localparam int IWL = clog2_min1(SZ);
      localparam int NWL = clog2_min1(CN);

      logic [AWL-1:0] w_addr;
      logic [IWL-1:0] x_idx;
      logic [NWL-1:0] r_idx;
      logic [31:0]    w_data, mac_w;
      logic           busy, done, w_rd_en, mac_en, mac_first, res_valid;

      nn_layer_sequencer #(.SIZE(SZ), .COUNT(CN), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_v[gi]), .abort(abort_v[gi]),
        .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_addr(w_addr),
        .w_data(w_data), .mac_en(mac_en), .mac_first(mac_first), .mac_w(mac_w),
        .mac_x_idx(x_idx), .res_valid(res_valid), .res_idx(r_idx),
        .res_ready(ready_v[gi])
      );

      nn_weight_rom #(.DEPTH(SZ * CN), .DW(32)) rom (
        .clk(clk), .rd_en(w_rd_en), .addr(w_addr), .data(w_data),
        .ld_en(ld_en_v[gi]), .ld_addr(AWL'(ld_addr_v[gi])), .ld_data(ld_data_v[gi])
      );

      assign busy_x[gi]   = busy;
      assign done_x[gi]   = done;
      assign rd_x[gi]     = w_rd_en;
      assign mac_en_x[gi] = mac_en;
      assign first_x[gi]  = mac_first;
      assign rv_x[gi]     = res_valid;
      assign addr_x[gi]   = 8'(w_addr);
      assign xi_x[gi]     = 8'(x_idx);
      assign ri_x[gi]     = 8'(r_idx);
      assign mw_x[gi]     = mac_w;
    end
  endgenerate

  // Expected events per instance: 0 read address, 1 MAC term, 2 result handshake, 3 done.
  ev_t         evq [2][4][$];
  sc_t         sc_q[$];
  logic [31:0] rom_m [2][8];
  int          win_lo [8];
  int          win_hi [8];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        final_req = 1'b0;
  logic        final_ack = 1'b0;
  logic [1:0]  hold_prev = '0;
  logic [1:0][7:0] prev_idx;

  function automatic int sz_of(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  function automatic int cn_of(input int u);
    return (u == 0) ? 3 : 4;
  endfunction

  task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", nm, u, cyc, act, exp);
    end
  endtask

  task automatic take(input int u, input int k, input string nm, input logic present,
                      input logic [31:0] val, input logic first, input int idx);
    ev_t e;
    while (evq[u][k].size() > 0 && evq[u][k][0].cyc < cyc) begin
      e = evq[u][k].pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s missing inst%0d: expected at cycle %0d value %h, not seen", nm, u, e.cyc, e.val);
    end
    if (present) begin
      if (evq[u][k].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s unexpected inst%0d cycle %0d: got value %h, none required", nm, u, cyc, val);
      end else begin
        e = evq[u][k].pop_front();
        chk({nm, " cycle"}, u, cyc, e.cyc);
        if (k != 3) chk({nm, " value"}, u, val, e.val);
        if (k == 1) begin
          chk("mac_first", u, 32'(first), 32'(e.first));
          chk("mac_x_idx", u, 32'(idx), 32'(e.idx));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      take(u, 0, "w_addr", rd_x[u], 32'(addr_x[u]), 1'b0, 0);
      take(u, 1, "mac_w", mac_en_x[u], mw_x[u], first_x[u], int'(xi_x[u]));
      take(u, 2, "res_idx", rv_x[u] && ready_v[u], 32'(ri_x[u]), 1'b0, 0);
      take(u, 3, "done", done_x[u], 32'd0, 1'b0, 0);
      if (hold_prev[u] && rst_n) begin
        chk("res_valid held", u, 32'(rv_x[u]), 32'd1);
        chk("res_idx stable", u, 32'(ri_x[u]), 32'(prev_idx[u]));
      end
      hold_prev[u] <= rst_n && rv_x[u] && !ready_v[u] && !abort_v[u];
      prev_idx[u]  <= ri_x[u];
    end
    for (int j = sc_q.size() - 1; j >= 0; j--) begin
      if (sc_q[j].cyc == cyc) begin
        if (sc_q[j].kind == 0)
          chk("idle outputs", sc_q[j].u,
              32'({busy_x[sc_q[j].u], done_x[sc_q[j].u], rd_x[sc_q[j].u], mac_en_x[sc_q[j].u],
                   first_x[sc_q[j].u], rv_x[sc_q[j].u], addr_x[sc_q[j].u], xi_x[sc_q[j].u],
                   ri_x[sc_q[j].u]}), 32'd0);
        else
          chk("busy", sc_q[j].u, 32'(busy_x[sc_q[j].u]), 32'(sc_q[j].val));
        sc_q.delete(j);
      end
    end
    if (final_req && !final_ack) begin
      for (int u = 0; u < 2; u++)
        for (int k = 0; k < 4; k++)
          chk("events outstanding", u, evq[u][k].size(), 32'd0);
      chk("state checks outstanding", 0, sc_q.size(), 32'd0);
      final_ack <= 1'b1;
    end
  end

  task automatic push_sc(input int c, input int u, input int kind, input int val);
    sc_t s;
    s.cyc = c; s.u = u; s.kind = kind; s.val = val;
    sc_q.push_back(s);
  endtask

  task automatic push_ev(input int u, input int k, input int c, input logic [31:0] val,
                         input logic first, input int idx);
    ev_t e;
    e.cyc = c; e.val = val; e.first = first; e.idx = idx;
    evq[u][k].push_back(e);
  endtask

  function automatic bit keep(input int c, input int a_c, input int r_c, input bit incl);
    return (a_c < 0 || c < a_c || (incl && c == a_c)) && (r_c < 0 || c < r_c);
  endfunction

  // Reference timeline: neuron k reads SIZE words after the previous handshake,
  // then one drain cycle, then EMIT held for st[k] stall cycles.
  task automatic plan(input int u, input int base, input int st[8], input int a_c,
                      input int r_c, output int dn);
    int sz, cn, t, emit, hs, a;
    sz = sz_of(u);
    cn = cn_of(u);
    t  = base;
    for (int k = 0; k < cn; k++) begin
      for (int i = 0; i < sz; i++) begin
        a = k * sz + i;
        if (keep(t + 1 + i, a_c, r_c, 1'b1)) push_ev(u, 0, t + 1 + i, 32'(a), 1'b0, 0);
        if (keep(t + 2 + i, a_c, r_c, 1'b1)) push_ev(u, 1, t + 2 + i, rom_m[u][a], i == 0, i);
      end
      emit = t + sz + 2;
      hs   = emit + st[k];
      win_lo[k] = emit;
      win_hi[k] = hs;
      if (keep(hs, a_c, r_c, 1'b0)) push_ev(u, 2, hs, 32'(k), 1'b0, 0);
      t = hs;
    end
    dn = t + 1;
    if (keep(dn, a_c, r_c, 1'b1)) push_ev(u, 3, dn, 32'd0, 1'b0, 0);
    if (a_c < 0 && r_c < 0) push_sc(dn + 1, u, 0, 0);
    if (a_c >= 0) push_sc(a_c + 1, u, 0, 0);
    if (r_c >= 0) begin
      for (int v = 0; v < 2; v++) begin
        push_sc(r_c, v, 0, 0);
        push_sc(r_c + 1, v, 0, 0);
      end
    end
  endtask

  function automatic logic ready_for(input int u, input int c);
    for (int k = 0; k < cn_of(u); k++) begin
      if (c >= win_lo[k] && c < win_hi[k]) return 1'b0;
      if (c == win_hi[k]) return 1'b1;
    end
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run(input int u, input int st[8], input int a_off, input int r_off,
                     input int bs_off);
    int base, dn, a_c, r_c, stop;
    @(posedge clk); #1;
    base = cyc;
    a_c  = (a_off < 0) ? -1 : base + a_off;
    r_c  = (r_off < 0) ? -1 : base + r_off;
    plan(u, base, st, a_c, r_c, dn);
    if (bs_off >= 0) push_sc(base + bs_off + 1, u, 1, 1);
    stop = (a_c >= 0) ? a_c + 1 : (r_c >= 0) ? r_c + 2 : dn + 1;
    $display("run inst%0d start cycle %0d abort %0d reset %0d done expected %0d",
             u, base, a_c, r_c, dn);
    for (int c = base; c <= stop; c++) begin
      if (c > base) begin
        @(posedge clk); #1;
      end
      start_v[u] = (c == base) || (bs_off >= 0 && c == base + bs_off);
      abort_v[u] = (c == a_c);
      ready_v[u] = ready_for(u, c);
      if (r_c >= 0 && c == r_c + 1) rst_n = 1'b1;
      if (c == r_c) begin
        #1;
        rst_n = 1'b0;
      end
    end
    @(posedge clk); #1;
    start_v[u] = 1'b0;
    abort_v[u] = 1'b0;
    ready_v[u] = 1'b0;
  endtask

  task automatic load_roms(input bit rand0);
    logic [31:0] val;
    for (int a = 0; a < 6; a++) begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
        if (a < sz_of(u) * cn_of(u)) begin
          val = (u == 0 && !rand0) ? 32'h11 + 32'(a) : $urandom;
          rom_m[u][a]  = val;
          ld_en_v[u]   = 1'b1;
          ld_addr_v[u] = 8'(a);
          ld_data_v[u] = val;
        end else begin
          ld_en_v[u] = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    ld_en_v = '0;
  endtask

  initial begin
    int st[8];
    int a_off, dn_off;
    ld_addr_v = '0;
    ld_data_v = '0;
    for (int u = 0; u < 2; u++) begin
      push_sc(1, u, 0, 0);
      push_sc(2, u, 0, 0);
      push_sc(4, u, 0, 0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    load_roms(1'b0);

    st = '{default: 0};
    run(0, st, -1, -1, 3);
    st[1] = 5;
    run(0, st, -1, -1, -1);
    st = '{default: 0};
    run(1, st, -1, -1, -1);
    run(0, st, 6, -1, -1);
    run(0, st, -1, -1, -1);

    @(posedge clk); #1;
    start_v[1] = 1'b1;
    abort_v[1] = 1'b1;
    push_sc(cyc + 1, 1, 0, 0);
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    abort_v[1] = 1'b0;
    repeat (2) @(posedge clk);

    load_roms(1'b1);
    for (int r = 0; r < 8; r++) begin
      int u;
      u = r % 2;
      st = '{default: 0};
      dn_off = 1 + cn_of(u) * (sz_of(u) + 2);
      for (int k = 0; k < cn_of(u); k++) begin
        st[k] = $urandom_range(0, 3);
        dn_off += st[k];
      end
      a_off = (r % 3 == 2) ? $urandom_range(1, dn_off) : -1;
      run(u, st, a_off, -1, -1);
    end

    st = '{default: 0};
    st[0] = 3;
    run(0, st, -1, 5, -1);
    st = '{default: 0};
    run(0, st, -1, -1, -1);

    repeat (3) @(posedge clk);
    final_req = 1'b1;
    for (int t = 0; t < 5 && !final_ack; t++) @(posedge clk);
    if (!final_ack) begin
      $display("FAIL final_check: monitor acknowledged 0, required 1");
      $fatal(1, "final check timeout");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
